// File: rtl/timer_run_ctrl_pkg.sv
// Shared constants for the display-timer control path: FSM state codes,
// default clock rates and a counter-width helper.
package timer_run_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    localparam int DEF_CLK_HZ  = 50_000_000;
    localparam int DEF_TICK_HZ = 10;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timer_run_ctrl_if.sv
// Pushbutton inputs and timer control outputs of the run controller.
interface timer_run_ctrl_if;

    logic key_start_n;
    logic key_clear_n;
    logic tick;
    logic clear;
    logic running;
    logic paused;

    modport master (
        output key_start_n, key_clear_n,
        input  tick, clear, running, paused
    );

    modport slave (
        input  key_start_n, key_clear_n,
        output tick, clear, running, paused
    );

endinterface

// File: rtl/timer_run_ctrl_key_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stable-sample debounce counter
// and a registered one-cycle pulse on each accepted press.
module key_debounce
    import timer_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized key disagrees with the accepted level.
    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        level_dly_d = level_q;
        press_d     = level_dly_q & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b1;
            level_dly_q <= 1'b1;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/timer_run_ctrl.sv
// Run controller for the mod-N display timer: debounced start/stop and clear keys,
// IDLE/RUN/PAUSE state machine and the count-enable prescaler.
module timer_run_ctrl
    import timer_run_ctrl_pkg::*;
#(
    parameter int CLK_HZ          = DEF_CLK_HZ,
    parameter int TICK_HZ         = DEF_TICK_HZ,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    timer_run_ctrl_if.slave bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = cnt_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    if (DIV < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_check
        $error("timer_run_ctrl: DIV and DEBOUNCE_CYCLES must both be >= 2");
    end

    logic          start_ev;
    logic          clear_ev;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic          running_q, running_d;
    logic          paused_q, paused_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.key_start_n),
        .press (start_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (bus.key_clear_n),
        .press (clear_ev)
    );

    // Clear beats start; the prescaler only advances while staying in RUN so a
    // pause-transition edge neither ticks nor moves the phase.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;
        if (clear_ev) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_ev) state_d = ST_RUN;
                ST_RUN:   if (start_ev) state_d = ST_PAUSE;
                ST_PAUSE: if (start_ev) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
        if (state_d == ST_IDLE) begin
            presc_d = '0;
        end else if (state_q == ST_RUN && state_d == ST_RUN) begin
            tick_d  = (presc_q == PRESC_LAST);
            presc_d = tick_d ? '0 : presc_q + 1'b1;
        end
        running_d = (state_d == ST_RUN);
        paused_d  = (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            clear_q   <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            clear_q   <= clear_d;
            running_q <= running_d;
            paused_q  <= paused_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.clear   = clear_q;
    assign bus.running = running_q;
    assign bus.paused  = paused_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Self-checking bench for timer_run_ctrl: a cycle reference model pushes the expected
// outputs per clock into a scoreboard queue that is popped and compared on each falling edge.
module tb_timer_run_ctrl;
    import timer_run_ctrl_pkg::*;

    localparam int DIV = 10;
    localparam int DEB = 4;

    typedef struct {
        int         cyc;
        logic [3:0] outs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic keyStartN = 1'b1;
    logic keyClearN = 1'b1;

    int   vecCount = 0;
    int   missCount = 0;
    int   cyc = 0;
    exp_t expQ[$];

    logic [1:0] mState = ST_IDLE;
    int   mPresc = 0;
    logic accS = 1'b1, accC = 1'b1, prevS = 1'b1, prevC = 1'b1;
    int   chgS = 0, chgC = 0, pendStart = -1, pendClear = -1;

    timer_run_ctrl_if bus ();
    assign bus.key_start_n = keyStartN;
    assign bus.key_clear_n = keyClearN;

    timer_run_ctrl #(
        .CLK_HZ          (100),
        .TICK_HZ         (10),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vecCount++;
        if (actual != expected) begin
            missCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", tag, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic c, input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            keyStartN = s;
            keyClearN = c;
        end
    endtask

    // Reference: a key level is accepted once held for 2+DEB edges, the press pulse
    // follows one edge later and the state changes on the edge after that.
    always @(posedge clk) begin : refModel
        exp_t e;
        logic doS, doC, tickE, clearE;
        cyc++;
        tickE  = 1'b0;
        clearE = 1'b0;
        if (!rst_n) begin
            mState = ST_IDLE;
            mPresc = 0;
            accS = 1'b1;
            accC = 1'b1;
            chgS = cyc;
            chgC = cyc;
            prevS = keyStartN;
            prevC = keyClearN;
            pendStart = -1;
            pendClear = -1;
        end else begin
            if (keyStartN != prevS) chgS = cyc - 1;
            if (keyClearN != prevC) chgC = cyc - 1;
            prevS = keyStartN;
            prevC = keyClearN;
            doS = (pendStart == cyc);
            doC = (pendClear == cyc);
            if (keyStartN != accS && cyc - chgS == 2 + DEB) begin
                accS = keyStartN;
                if (!keyStartN) pendStart = cyc + 2;
            end
            if (keyClearN != accC && cyc - chgC == 2 + DEB) begin
                accC = keyClearN;
                if (!keyClearN) pendClear = cyc + 2;
            end
            if (doC) begin
                mState = ST_IDLE;
                mPresc = 0;
                clearE = 1'b1;
            end else if (doS) begin
                mState = (mState == ST_RUN) ? ST_PAUSE : ST_RUN;
            end else if (mState == ST_RUN) begin
                tickE  = (mPresc == DIV - 1);
                mPresc = tickE ? 0 : mPresc + 1;
            end
        end
        e.cyc  = cyc;
        e.outs = {tickE, clearE, mState == ST_RUN, mState == ST_PAUSE};
        expQ.push_back(e);
    end

    // Reset forces all outputs low at once, even in the cycle it is asserted.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [3:0] want;
        while (expQ.size() > 0 && expQ[0].cyc < cyc) void'(expQ.pop_front());
        if (expQ.size() == 0) begin
            checkOutput("sbDepth", expQ.size(), 1);
        end else begin
            e = expQ.pop_front();
            want = rst_n ? e.outs : 4'b0000;
            checkOutput("outs", int'({bus.tick, bus.clear, bus.running, bus.paused}), int'(want));
        end
    end

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 5);

        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b1, 1'b1, 70);
        checkOutput("startRun", int'(bus.running), 1);

        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.tick) begin
                seen = 1;
                break;
            end
        end
        checkOutput("waitTick", seen, 1);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 100);
        checkOutput("pauseHeld", int'(bus.paused), 1);
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 40);
        checkOutput("resumeRun", int'(bus.running), 1);

        for (int i = 0; i < 15; i++) applyStimulus((i % 2) != 0, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 12);
        applyStimulus(1'b1, 1'b1, 30);
        checkOutput("bouncePause", int'(bus.paused), 1);

        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 30);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 30);
        checkOutput("clearIdle", int'({bus.running, bus.paused}), 0);
        applyStimulus(1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 30);

        applyStimulus(1'b0, 1'b1, 200);
        checkOutput("holdRun", int'({bus.running, bus.paused}), 2);
        applyStimulus(1'b1, 1'b1, 30);
        checkOutput("holdRelease", int'(bus.running), 1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("rstAsync", int'({bus.tick, bus.clear, bus.running, bus.paused}), 0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 30);
        checkOutput("postRstIdle", int'({bus.running, bus.paused}), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
